fetch_prefetch_unit: RTL

//   IF stage front-end. Issues in-order instruction reads to imem and buffers returned words with their PCs.

---
 rtl/fetch_prefetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// IF-stage prefetcher: credit-limited in-order imem reads feeding a small FIFO of {pc, instr}.
// Optional FETCH_PERF_CNT_EN adds saturating discard/bubble counters.
module fetch_prefetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            InstrValidF,
  output logic [31:0]     perf_discard_cnt,
  output logic [31:0]     perf_bubble_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outst, discard;
  logic [XLEN-1:0] fetch_pc, rsp_pc, target_pc;
  logic            accept, drop, push, deq, empty;
  logic            unused_tgt;

  assign unused_tgt = ^PCTargetE[1:0];
  assign target_pc  = {PCTargetE[XLEN-1:2], 2'b00};
  assign empty      = (count == '0);

  // Credit rule: every request in flight already owns a FIFO slot.
  assign imem_req_valid = rst && (int'(outst) < MAX_OUTST) &&
                          (int'(count) + int'(outst) < DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign drop           = imem_rsp_valid && (PCSrcE || (discard != '0));
  assign push           = imem_rsp_valid && !drop;
  assign deq            = !empty && !StallF && !PCSrcE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      outst    <= '0;
      discard  <= '0;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else begin
      outst <= outst + OW'(accept) - OW'(imem_rsp_valid);
      if (PCSrcE) begin
        // Everything still in flight after this edge belongs to the old path.
        discard  <= outst + OW'(accept) - OW'(imem_rsp_valid);
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (drop)   discard  <= discard - OW'(1);
        if (push) begin
          rsp_pc <= rsp_pc + XLEN'(4);
          tail   <= tail + AW'(1);
        end
        if (deq) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail] <= imem_rsp_data;
      pc_q[tail]    <= rsp_pc;
    end
  end

  // Head presentation; when empty PCF shows the PC of the next expected word.
  assign InstrValidF = !empty;
  assign InstrF      = empty ? NOP : instr_q[head];
  assign PCF         = empty ? rsp_pc : pc_q[head];
  assign PCPlus4F    = PCF + XLEN'(4);

  assert property (@(posedge clk) disable iff (!rst) !(push && (count == CW'(DEPTH))));

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] discard_cnt, bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (drop)            discard_cnt <= sat_inc(discard_cnt);
      if (empty && !StallF) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  assign perf_discard_cnt = discard_cnt;
  assign perf_bubble_cnt  = bubble_cnt;
`else
  assign perf_discard_cnt = 32'h0;
  assign perf_bubble_cnt  = 32'h0;
`endif

endmodule
